// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand/issue stage: widths, op encodings,
// the registered issue payload and the "does this op write" helper.
package alu_operand_stage_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 8;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_CMP  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    // Payload presented to the ALU
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        op_t               op;
        logic [ADDR_W-1:0] rc;
        logic              wr;
    } issue_t;

    // Only add and nand produce a register result
    function automatic logic op_writes(input logic [1:0] op);
        return (op == 2'(OP_ADD)) || (op == 2'(OP_NAND));
    endfunction

endpackage

// File: rtl/alu_operand_stage_reg_file_2r1w.sv
// 8 x 16 general register file: two asynchronous read ports, one
// synchronous write port, asynchronous active-high reset to zero.
//   clk, reset        clock / async reset
//   raddr_a, rdata_a  read port A
//   raddr_b, rdata_b  read port B
//   we, waddr, wdata  write port (captured on rising edge)
module reg_file_2r1w
    import alu_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [NREG];

    // Storage with write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous reads
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage in front of the 16-bit ALU. Reads operands (with writeback
// bypass), tracks in-flight destinations in a busy scoreboard, stalls on
// RAW/WAW hazards and presents a registered operation to the ALU.
//   clk, reset                    clock / async active-high reset
//   in_valid/in_ready             decoded-op handshake (in_ready is combinational)
//   in_op, in_ra, in_rb, in_rc    op and register indices
//   in_imm_en, in_imm             immediate replaces source B
//   wb_en, wb_addr, wb_data       result writeback
//   out_valid/out_ready           ALU handshake
//   aluA, aluB, opSel, out_rc, out_wr  registered operation to ALU
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_ra,
    input  logic [ADDR_W-1:0] in_rb,
    input  logic [ADDR_W-1:0] in_rc,
    input  logic              in_imm_en,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] aluA,
    output logic [DATA_W-1:0] aluB,
    output logic [1:0]        opSel,
    output logic [ADDR_W-1:0] out_rc,
    output logic              out_wr
);

    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    issue_t            out_q;
    issue_t            issue_c;
    logic              dest_wr;
    logic              uses_src;
    logic              wb_hit_a;
    logic              wb_hit_b;
    logic              wb_hit_c;
    logic              haz_a;
    logic              haz_b;
    logic              haz_c;
    logic              accept;

    reg_file_2r1w u_rf (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (in_ra),
        .rdata_a (rf_a),
        .raddr_b (in_rb),
        .rdata_b (rf_b),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // Hazard detection; a writeback landing this cycle resolves the hazard
    always_comb begin
        dest_wr  = op_writes(in_op);
        uses_src = (in_op != 2'(OP_NONE));
        wb_hit_a = wb_en && (wb_addr == in_ra);
        wb_hit_b = wb_en && (wb_addr == in_rb);
        wb_hit_c = wb_en && (wb_addr == in_rc);
        haz_a    = uses_src && busy[in_ra] && !wb_hit_a;
        haz_b    = uses_src && !in_imm_en && busy[in_rb] && !wb_hit_b;
        haz_c    = dest_wr && busy[in_rc] && !wb_hit_c;
        in_ready = (!out_valid || out_ready) && !haz_a && !haz_b && !haz_c;
        accept   = in_valid && in_ready;
    end

    // Operand selection with writeback bypass
    always_comb begin
        issue_c.a  = wb_hit_a ? wb_data : rf_a;
        issue_c.b  = in_imm_en ? in_imm : (wb_hit_b ? wb_data : rf_b);
        issue_c.op = op_t'(in_op);
        issue_c.rc = in_rc;
        issue_c.wr = dest_wr;
    end

    // Scoreboard next state: a new claim beats a same-cycle release
    always_comb begin
        busy_nxt = busy;
        if (wb_en) begin
            busy_nxt[wb_addr] = 1'b0;
        end
        if (accept && dest_wr) begin
            busy_nxt[in_rc] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Output register; data fields hold when the slot drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_q     <= issue_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign aluA   = out_q.a;
    assign aluB   = out_q.b;
    assign opSel  = out_q.op;
    assign out_rc = out_q.rc;
    assign out_wr = out_q.wr;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios followed by
// random traffic, all compared against a register/scoreboard reference model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [2:0]  in_ra, in_rb, in_rc;
    logic        in_imm_en;
    logic [15:0] in_imm;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] aluA, aluB;
    logic [1:0]  opSel;
    logic [2:0]  out_rc;
    logic        out_wr;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] m_reg [8];
    bit          m_busy [8];
    bit          m_valid;
    logic [15:0] m_a, m_b;
    logic [1:0]  m_op;
    logic [2:0]  m_rc;
    bit          m_wr;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .in_rc     (in_rc),
        .in_imm_en (in_imm_en),
        .in_imm    (in_imm),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluA      (aluA),
        .aluB      (aluB),
        .opSel     (opSel),
        .out_rc    (out_rc),
        .out_wr    (out_wr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_a = '0; m_b = '0; m_op = '0; m_rc = '0; m_wr = 1'b0;
    endtask

    function automatic bit writes(input logic [1:0] op);
        return op == 2'd1 || op == 2'd3;
    endfunction

    // Is register r still waiting for a result that is not arriving now?
    function automatic bit pending(input logic [2:0] r);
        return m_busy[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic bit exp_ready();
        bit stall;
        stall = 1'b0;
        if (in_op != 2'd0) begin
            if (pending(in_ra)) stall = 1'b1;
            if (!in_imm_en && pending(in_rb)) stall = 1'b1;
        end
        if (writes(in_op) && pending(in_rc)) stall = 1'b1;
        return (!m_valid || out_ready) && !stall;
    endfunction

    function automatic logic [15:0] read_src(input logic [2:0] r);
        return (wb_en && wb_addr == r) ? wb_data : m_reg[r];
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".aluA"},      32'(aluA),      32'(m_a));
        chk({tag, ".aluB"},      32'(aluB),      32'(m_b));
        chk({tag, ".opSel"},     32'(opSel),     32'(m_op));
        chk({tag, ".out_rc"},    32'(out_rc),    32'(m_rc));
        chk({tag, ".out_wr"},    32'(out_wr),    32'(m_wr));
    endtask

    // One clock: inputs already driven after the previous negedge.
    task automatic cycle(input string tag);
        bit rdy, acc;
        #1;
        rdy = exp_ready();
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        @(posedge clk);
        acc = in_valid && rdy;
        if (acc) begin
            m_valid = 1'b1;
            m_a  = read_src(in_ra);
            m_b  = in_imm_en ? in_imm : read_src(in_rb);
            m_op = in_op;
            m_rc = in_rc;
            m_wr = writes(in_op);
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (wb_en) begin
            m_reg[wb_addr]  = wb_data;
            m_busy[wb_addr] = 1'b0;
        end
        if (acc && writes(in_op)) m_busy[in_rc] = 1'b1;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic set_op(input bit v, input logic [1:0] op, input logic [2:0] ra,
                          input logic [2:0] rb, input logic [2:0] rc,
                          input bit ie, input logic [15:0] imm);
        in_valid = v; in_op = op; in_ra = ra; in_rb = rb; in_rc = rc;
        in_imm_en = ie; in_imm = imm;
    endtask

    task automatic set_wb(input bit en, input logic [2:0] a, input logic [15:0] d);
        wb_en = en; wb_addr = a; wb_data = d;
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        set_op(0, 2'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0);
        set_wb(0, 3'd0, 16'h0);
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Preload R1=25, R2=40 then add R3 = R1 + R2
        set_wb(1, 3'd1, 16'd25);  cycle("wb1");
        set_wb(1, 3'd2, 16'd40);  cycle("wb2");
        set_wb(0, 3'd0, 16'd0);
        set_op(1, 2'd1, 3'd1, 3'd2, 3'd3, 0, 16'h0);
        cycle("add1");
        chk("add1.aluA_const", 32'(aluA), 32'd25);
        chk("add1.aluB_const", 32'(aluB), 32'd40);
        chk("add1.wr_const",   32'(out_wr), 32'd1);

        // RAW on R3 stalls until its writeback, then bypasses
        set_op(1, 2'd1, 3'd3, 3'd1, 3'd6, 0, 16'h0);
        cycle("raw_stall0");
        chk("raw_stall.ready_const", 32'(in_ready), 32'd0);
        cycle("raw_stall1");
        set_wb(1, 3'd3, 16'd65);
        cycle("raw_bypass");
        chk("raw_bypass.aluA_const", 32'(aluA), 32'd65);
        set_wb(0, 3'd0, 16'd0);

        // ALU backpressure: outputs hold for 5 cycles, then accept resumes
        out_ready = 1'b0;
        set_op(1, 2'd1, 3'd1, 3'd2, 3'd7, 0, 16'h0);
        for (int i = 0; i < 5; i++) cycle("hold");
        chk("hold.aluA_const", 32'(aluA), 32'd65);
        out_ready = 1'b1;
        cycle("release");
        chk("release.aluA_const", 32'(aluA), 32'd25);

        // Compare with immediate ignores busy rb (R6)
        set_op(1, 2'd2, 3'd1, 3'd6, 3'd6, 1, 16'h0019);
        cycle("cmp_imm");
        chk("cmp_imm.aluB_const", 32'(aluB), 32'h19);
        set_op(1, 2'd1, 3'd6, 3'd1, 3'd0, 0, 16'h0);
        cycle("r6_still_busy");

        // Same-cycle release and re-claim of R4: claim wins
        set_op(1, 2'd3, 3'd1, 3'd2, 3'd4, 0, 16'h0);
        cycle("nand_r4");
        set_wb(1, 3'd4, 16'h1234);
        cycle("nand_r4_again");
        set_wb(0, 3'd0, 16'd0);
        set_op(1, 2'd1, 3'd4, 3'd1, 3'd0, 0, 16'h0);
        cycle("r4_busy");
        chk("r4_busy.ready_const", 32'(in_ready), 32'd0);

        // Writeback to non-busy register, then claim R5, then async reset
        set_wb(1, 3'd0, 16'hbeef);
        set_op(1, 2'd1, 3'd0, 3'd0, 3'd5, 0, 16'h0);
        cycle("claim_r5");
        set_wb(0, 3'd0, 16'd0);
        set_op(1, 2'd1, 3'd5, 3'd5, 3'd0, 0, 16'h0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("async_reset");
        chk("async_reset.ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        set_op(1, 2'd1, 3'd1, 3'd2, 3'd3, 0, 16'h0);
        cycle("post_reset");
        chk("post_reset.aluA_const", 32'(aluA), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_op($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                   16'($urandom));
            set_wb($urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 16'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the 16-bit ALU.
- Holds the 8 x 16-bit general register file and a per-register busy scoreboard.
- Accepts decoded operations over a valid/ready handshake, reads and bypasses operands, stalls on hazards, and presents registered aluA/aluB/opSel to the ALU.
- ALU results return through the writeback port.

Parameters:
- DATA_W, 16, operand/register width
- NREG, 8, number of general registers
- ADDR_W, 3, register index width (log2 NREG)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded operation offered
- in_ready  out  1  stage accepts operation this cycle
- in_op  in  2  00 none, 01 add, 10 compare, 11 nand
- in_ra  in  ADDR_W  source A register index
- in_rb  in  ADDR_W  source B register index
- in_rc  in  ADDR_W  destination register index
- in_imm_en  in  1  1: aluB taken from in_imm, rb ignored
- in_imm  in  DATA_W  immediate operand
- wb_en  in  1  writeback strobe from ALU/result stage
- wb_addr  in  ADDR_W  writeback register index
- wb_data  in  DATA_W  writeback value
- out_valid  out  1  registered operation valid to ALU
- out_ready  in  1  ALU consumes operation this cycle
- aluA  out  DATA_W  operand A
- aluB  out  DATA_W  operand B
- opSel  out  2  ALU operation select, same encoding as in_op
- out_rc  out  ADDR_W  destination index carried to writeback
- out_wr  out  1  1 if the operation writes in_rc (add, nand)

Behaviour:
- Reset (async, immediate): all registers 0, busy[] 0, out_valid 0, aluA/aluB 0, opSel 00, out_rc 0, out_wr 0. A reset mid-stall discards the held operation; no writeback is expected afterward.
- Writes: dest_wr = (in_op==01 || in_op==11). Compare and none never write and never set busy.
- Source hazards:
  - hazA = busy[in_ra] && !(wb_en && wb_addr==in_ra).
  - hazB = !in_imm_en && busy[in_rb] && !(wb_en && wb_addr==in_rb).
  - An op 00 (none) ignores both sources: no hazard.
- WAW hazard: hazC = dest_wr && busy[in_rc] && !(wb_en && wb_addr==in_rc).
- Handshake: in_ready = (!out_valid || out_ready) && !hazA && !hazB && !hazC. Accept = in_valid && in_ready. in_ready does not depend on in_valid.
- Operand read: combinational read with bypass. If wb_en && wb_addr==index, use wb_data, else the register contents. aluB = in_imm when in_imm_en.
- Latency: an operation accepted at edge N is presented at outputs after edge N (one cycle).
- Output register:
  - On accept, load aluA/aluB/opSel/out_rc/out_wr and set out_valid=1.
  - Else if out_ready, clear out_valid=0; data fields hold their last values.
  - While out_valid && !out_ready, all outputs hold stable.
- Register file: on wb_en, write wb_data to reg[wb_addr] at the edge.
- Scoreboard:
  - On accept with dest_wr, set busy[in_rc].
  - On wb_en, clear busy[wb_addr].
  - Same index set and cleared in the same cycle: set wins.
- Writeback to a non-busy register is legal: the data is written and busy stays 0.
- Full throughput: back-to-back independent operations are accepted one per cycle while out_ready=1.
- No flag state in this block; carry/zero remain owned by the ALU.

Decomposition:
- Shared package:
  - DATA_W, ADDR_W, NREG.
  - Op encodings OP_NONE=2'b00, OP_ADD=2'b01, OP_CMP=2'b10, OP_NAND=2'b11.
  - Helper function op_writes(op).
- One sub-module: reg_file_2r1w.
  - 8x16, two asynchronous read ports, one synchronous write port, async reset to 0.
  - Bypass and scoreboard live in alu_operand_stage.

Test Plan:
- Reset then wb R1=25, R2=40; issue add ra=1 rb=2 rc=3 -> next cycle out_valid=1, aluA=25, aluB=40, opSel=01, out_rc=3, out_wr=1, busy[3]=1.
- Issue add rc=3, then add ra=3 rb=1 with no wb -> in_ready=0. Stall holds until wb_en addr=3 data=65. In that cycle in_ready=1 and the accepted aluA=65 (bypass).
- out_ready=0 with out_valid=1 -> in_ready=0; aluA/aluB/opSel stable for 5 cycles. Raise out_ready -> the pending in_valid operation is accepted the same cycle.
- Compare ra=1, in_imm_en=1, in_imm=0x0019 with rb pointing to a busy register -> accepted (no stall), aluB=0x0019, out_wr=0, busy unchanged.
- Same-cycle wb_en addr=4 (clearing busy[4]) and accept of nand rc=4 -> busy[4]=1 afterward. A following read of R4 stalls.
- Assert reset with out_valid=1 and busy[5]=1 -> out_valid=0, busy all 0, registers 0 immediately, without waiting for a clock edge.
